tcdm_rx_sid_sched: RTL and testbench

Per-SID transaction scheduler for the TCDM RX unpacker.
- Gates incoming RX commands with a per-SID pending-command limit.
- Tracks outstanding transactions per SID and drives the unpacker's active-SID select.
- Picks the active SID round-robin among SIDs with pending work and available RX data.
- Holds the selection until the transaction's EOP beat is accepted, or yields after a starvation timeout.

---
 rtl/tcdm_rx_sid_sched.sv | 161 ++++++++++++++++
 tb/tb_tcdm_rx_sid_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_rx_sid_sched.sv
// rtl/tcdm_rx_sid_sched.sv - per-SID command gating and round-robin active-SID scheduler for the TCDM RX unpacker
module tcdm_rx_sid_sched #(
  parameter int TRANS_SID_WIDTH = 2,
  parameter int MAX_PENDING     = 4,
  parameter int STARVE_LIMIT    = 16,
  localparam int SID_CONTEXTS   = 2 ** TRANS_SID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
  input  logic                       cmd_req_i,
  output logic                       cmd_gnt_o,
  output logic                       cmd_req_o,
  input  logic                       cmd_gnt_i,
  input  logic [SID_CONTEXTS-1:0]    data_avail_i,
  input  logic                       beat_req_i,
  input  logic                       beat_gnt_i,
  input  logic                       beat_eop_i,
  output logic [TRANS_SID_WIDTH-1:0] act_sid_o,
  output logic                       act_valid_o,
  output logic [SID_CONTEXTS-1:0]    pend_o,
  output logic                       err_o
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef logic [TRANS_SID_WIDTH-1:0] sid_t;
  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_pend [SID_CONTEXTS];
  sid_t                  r_act_sid;
  logic                  r_act_valid;
  sid_t                  r_last_sid;
  logic [STV_W-1:0]      r_starve;
  logic                  r_err;

  logic                  w_full;
  logic                  w_push;
  logic                  w_acc;
  logic                  w_done;
  logic                  w_sat_err;
  logic                  w_select;
  logic                  w_starve_hit;
  logic                  w_found;
  sid_t                  w_pick;
  logic [SID_CONTEXTS-1:0] w_elig;
  logic [SID_CONTEXTS-1:0] w_inc;
  logic [SID_CONTEXTS-1:0] w_dec;

  // A SID at its pending limit blocks both directions of the command handshake.
  assign w_full    = (r_pend[cmd_sid_i] == CNT_W'(MAX_PENDING));
  assign cmd_req_o = cmd_req_i && !w_full;
  assign cmd_gnt_o = cmd_gnt_i && !w_full;
  assign w_push    = cmd_req_i && cmd_gnt_o;
  assign w_acc     = beat_req_i && beat_gnt_i;
  assign w_done    = w_acc && beat_eop_i && r_act_valid;

  assign w_starve_hit = (STARVE_LIMIT != 0) && (r_starve == STV_W'(STARVE_LIMIT));

  assign act_sid_o   = r_act_sid;
  assign act_valid_o = r_act_valid;
  assign err_o       = r_err;

  // Per-SID increment/decrement requests, eligibility and pending flags.
  always_comb begin
    w_inc  = '0;
    w_dec  = '0;
    w_elig = '0;
    pend_o = '0;
    for (int s = 0; s < SID_CONTEXTS; s++) begin
      w_inc[s]  = w_push && (cmd_sid_i == sid_t'(s));
      w_dec[s]  = w_done && (r_act_sid == sid_t'(s));
      pend_o[s] = (r_pend[s] != '0);
      w_elig[s] = pend_o[s] && data_avail_i[s];
    end
  end

  // A decrement with no matching push on an empty counter is a protocol error.
  assign w_sat_err = w_done && !w_inc[r_act_sid] && (r_pend[r_act_sid] == '0);

  // Round-robin search starting just after the last serviced SID.
  always_comb begin
    sid_t w_idx;
    w_idx   = '0;
    w_found = 1'b0;
    w_pick  = r_last_sid;
    for (int i = 1; i <= SID_CONTEXTS; i++) begin
      w_idx = r_last_sid + sid_t'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Pending counters: simultaneous push and done on one SID cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SID_CONTEXTS; s++) r_pend[s] <= '0;
    end else begin
      for (int s = 0; s < SID_CONTEXTS; s++) begin
        if (w_inc[s] && !w_dec[s]) begin
          r_pend[s] <= r_pend[s] + CNT_W'(1);
        end else if (w_dec[s] && !w_inc[s] && (r_pend[s] != '0)) begin
          r_pend[s] <= r_pend[s] - CNT_W'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: done takes priority over a starvation yield.
  always_comb begin
    w_state_nxt = r_state;
    w_select    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LOCK;
          w_select    = 1'b1;
        end
      end
      S_LOCK: begin
        if (w_done || w_starve_hit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Selection, round-robin pointer, starvation counter and error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_act_sid   <= '0;
      r_act_valid <= 1'b0;
      r_last_sid  <= '1;
      r_starve    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err       <= (w_acc && !r_act_valid) || w_sat_err;
      r_act_valid <= (w_state_nxt == S_LOCK);
      if (w_select) r_act_sid <= w_pick;
      if ((r_state == S_LOCK) && (w_state_nxt == S_IDLE)) r_last_sid <= r_act_sid;
      if ((r_state != S_LOCK) || (w_state_nxt != S_LOCK)) begin
        r_starve <= '0;
      end else if (w_acc || data_avail_i[r_act_sid]) begin
        r_starve <= '0;
      end else if (r_starve != '1) begin
        r_starve <= r_starve + STV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tcdm_rx_sid_sched.sv
// tb/tb_tcdm_rx_sid_sched.sv - scoreboard bench for tcdm_rx_sid_sched
module tb_tcdm_rx_sid_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd_sid;
  logic       cmd_req;
  logic       cmd_gnt_o;
  logic       cmd_req_o;
  logic       cmd_gnt;
  logic [3:0] data_avail;
  logic       beat_req;
  logic       beat_gnt;
  logic       beat_eop;
  logic [1:0] act_sid;
  logic       act_valid;
  logic [3:0] pend;
  logic       err;

  int sb[$];
  int n_cmp = 0;
  int n_err = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  tcdm_rx_sid_sched #(
    .TRANS_SID_WIDTH(2),
    .MAX_PENDING(4),
    .STARVE_LIMIT(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd_sid_i(cmd_sid),
    .cmd_req_i(cmd_req),
    .cmd_gnt_o(cmd_gnt_o),
    .cmd_req_o(cmd_req_o),
    .cmd_gnt_i(cmd_gnt),
    .data_avail_i(data_avail),
    .beat_req_i(beat_req),
    .beat_gnt_i(beat_gnt),
    .beat_eop_i(beat_eop),
    .act_sid_o(act_sid),
    .act_valid_o(act_valid),
    .pend_o(pend),
    .err_o(err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every new selection is compared against the next expected SID.
  always @(negedge clk) begin
    if (act_valid && !prev_valid) begin
      if (sb.size() == 0) check("sb_unexpected_sel", int'(act_sid), 99);
      else check("sid_order", int'(act_sid), sb.pop_front());
    end
    prev_valid <= act_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int sid);
    cmd_sid = 2'(sid);
    cmd_req = 1'b1;
    cmd_gnt = 1'b1;
    #1;
    check("push_gnt", int'(cmd_gnt_o), 1);
    tick();
    cmd_req = 1'b0;
    cmd_gnt = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!act_valid && cyc < max) begin
      tick();
      cyc++;
    end
    if (!act_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic eop_beat;
    beat_req = 1'b1;
    beat_gnt = 1'b1;
    beat_eop = 1'b1;
    tick();
    beat_req = 1'b0;
    beat_gnt = 1'b0;
    beat_eop = 1'b0;
  endtask

  task automatic serve(input int exp_bubble);
    int c;
    wait_valid(20, c);
    if (exp_bubble >= 0) check("bubble_len", c, exp_bubble);
    eop_beat();
    check("valid_drop", int'(act_valid), 0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    cmd_sid = 2'd0;
    cmd_req = 1'b1;
    cmd_gnt = 1'b1;
    data_avail = 4'b0000;
    beat_req = 1'b0;
    beat_gnt = 1'b0;
    beat_eop = 1'b0;
    repeat (2) tick();
    check("rst_valid", int'(act_valid), 0);
    check("rst_sid", int'(act_sid), 0);
    check("rst_err", int'(err), 0);
    check("rst_pend", int'(pend), 0);
    check("rst_cmd_req", int'(cmd_req_o), 1);
    check("rst_cmd_gnt", int'(cmd_gnt_o), 1);
    cmd_req = 1'b0;
    cmd_gnt = 1'b0;
    rst_n = 1'b1;
    tick();

    // single transaction on SID1
    data_avail = 4'b0010;
    sb.push_back(1);
    push_cmd(1);
    check("t1_pend", int'(pend), 2);
    check("t1_valid_early", int'(act_valid), 0);
    tick();
    check("t1_valid", int'(act_valid), 1);
    check("t1_sid", int'(act_sid), 1);
    eop_beat();
    check("t1_valid_drop", int'(act_valid), 0);
    check("t1_pend_clr", int'(pend), 0);

    // round-robin order 0,2,3 then 0 again
    data_avail = 4'hF;
    sb.push_back(0);
    sb.push_back(2);
    sb.push_back(3);
    push_cmd(0);
    push_cmd(2);
    push_cmd(3);
    serve(-1);
    wait_valid(20, c);
    check("t2_bubble_sid2", c, 1);
    sb.push_back(0);
    push_cmd(0);
    eop_beat();
    check("t2_valid_drop", int'(act_valid), 0);
    serve(1);
    serve(1);
    check("t2_pend_clr", int'(pend), 0);

    // pending limit on SID2
    data_avail = 4'b0100;
    sb.push_back(2);
    repeat (4) push_cmd(2);
    check("t3_locked", int'(act_valid), 1);
    cmd_sid = 2'd2;
    cmd_req = 1'b1;
    cmd_gnt = 1'b1;
    beat_req = 1'b1;
    beat_gnt = 1'b1;
    beat_eop = 1'b1;
    #1;
    check("t3_full_gnt", int'(cmd_gnt_o), 0);
    check("t3_full_req", int'(cmd_req_o), 0);
    tick();
    beat_req = 1'b0;
    beat_gnt = 1'b0;
    beat_eop = 1'b0;
    repeat (4) sb.push_back(2);
    check("t3_after_gnt", int'(cmd_gnt_o), 1);
    check("t3_after_req", int'(cmd_req_o), 1);
    tick();
    cmd_req = 1'b0;
    cmd_gnt = 1'b0;
    serve(-1);
    serve(1);
    serve(1);
    serve(1);
    check("t3_pend_clr", int'(pend), 0);

    // starvation yield on SID0 in favour of SID3
    data_avail = 4'b1001;
    sb.push_back(0);
    sb.push_back(3);
    sb.push_back(0);
    push_cmd(0);
    push_cmd(3);
    wait_valid(20, c);
    data_avail = 4'b1000;
    c = 0;
    while (act_valid && c < 40) begin
      tick();
      c++;
    end
    // 16 starved edges bring the counter to the limit; the yield registers on the next one
    check("t4_starve_cycles", c, 17);
    check("t4_pend_kept", int'(pend), 9);
    wait_valid(20, c);
    check("t4_sid3", int'(act_sid), 3);
    data_avail = 4'b1001;
    eop_beat();
    check("t4_valid_drop", int'(act_valid), 0);
    serve(1);
    check("t4_pend_clr", int'(pend), 0);

    // stray beat in IDLE and push+done on the same SID
    eop_beat();
    check("t5_idle_err", int'(err), 1);
    check("t5_idle_pend", int'(pend), 0);
    tick();
    check("t5_err_pulse", int'(err), 0);
    data_avail = 4'b0010;
    sb.push_back(1);
    push_cmd(1);
    wait_valid(20, c);
    cmd_sid = 2'd1;
    cmd_req = 1'b1;
    cmd_gnt = 1'b1;
    beat_req = 1'b1;
    beat_gnt = 1'b1;
    beat_eop = 1'b1;
    tick();
    cmd_req = 1'b0;
    cmd_gnt = 1'b0;
    beat_req = 1'b0;
    beat_gnt = 1'b0;
    beat_eop = 1'b0;
    sb.push_back(1);
    check("t5_same_pend", int'(pend), 2);
    check("t5_same_err", int'(err), 0);
    serve(1);
    check("t5_pend_clr", int'(pend), 0);

    // reset in the middle of a locked transaction
    data_avail = 4'hF;
    sb.push_back(1);
    push_cmd(1);
    push_cmd(2);
    push_cmd(3);
    check("t6_locked", int'(act_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(act_valid), 0);
    check("t6_rst_pend", int'(pend), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_rel_err", int'(err), 0);
    check("t6_rel_sid", int'(act_sid), 0);
    data_avail = 4'b0000;
    sb.push_back(1);
    sb.push_back(2);
    push_cmd(2);
    push_cmd(1);
    data_avail = 4'hF;
    serve(1);
    serve(1);
    check("t6_pend_clr", int'(pend), 0);

    tick();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
